alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Pipelined, parametrised successor to the team's combinational ALU: same 3-bit select plus carry-in operation encoding, now registered over two stages with valid/ready flow control.
- Adds Z/N flags, an architectural carry flag for multi-word carry chaining, and a sticky overflow flag.
- Sits between the operand-fetch/issue logic and the writeback path of the datapath.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).
- CHAIN_EN, 1, 1 = cin_sel honoured (carry chaining); 0 = cin_sel ignored, raw cin always used.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  stage 1 can accept; transfer when in_valid & in_ready.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- s  input  3  operation select.
- cin  input  1  carry-in / logic sub-select.
- cin_sel  input  1  1 = arithmetic carry-in taken from flag_c instead of cin.
- clr_sticky  input  1  synchronous clear of sticky_v.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts; transfer when out_valid & out_ready.
- g  output  WIDTH  result.
- cout  output  1  carry out of MSB (arith); 0 for logic ops.
- v  output  1  signed overflow (arith); 0 for logic ops.
- z  output  1  g == 0.
- n  output  1  g[WIDTH-1].
- flag_c  output  1  architectural carry flag.
- sticky_v  output  1  set by any completed arith op with v=1.

Behaviour:
- Reset (rst_n low, async): both stage valids 0, in_ready 1, out_valid 0, g 0, cout/v/z/n 0, flag_c 0, sticky_v 0. A reset mid-operation discards in-flight ops.
- Stage 1: registers a, b, s, cin, cin_sel on input transfer.
- Stage 2: computes combinationally from stage-1 registers and registers g/cout/v/z/n.
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput: 1 op/cycle.
- Flow control:
  - stage2_ready = ~out_valid | out_ready; stage1_ready = ~s1_valid | stage2_ready; in_ready = stage1_ready.
  - No combinational path from in_valid to in_ready.
  - Stalled outputs hold stable until accepted.
- Effective carry: c_eff = (CHAIN_EN & cin_sel) ? flag_c : cin. It is resolved in stage 2 at the moment the op moves into the output register, so back-to-back chained ops see the carry of the immediately preceding arith op.
- Arithmetic, s[2]=0, WIDTH+1-bit sum:
  - s[1:0]=00: A + c_eff.
  - 01: A + B + c_eff.
  - 10: A + ~B + c_eff.
  - 11: A + all-ones + c_eff.
  - cout = bit WIDTH. v = carry into MSB XOR cout.
- Logic, s[2]=1, selected by {s[0], cin}; raw cin always, cin_sel ignored, s[1] ignored:
  - 00 AND, 01 OR, 10 XOR, 11 NOT A.
  - cout = 0, v = 0.
- z and n are computed for every op.
- Flag update, on the same edge the result is loaded into the output register:
  - Arith op: flag_c <= cout; if v, sticky_v <= 1.
  - Logic op: flag_c unchanged.
- clr_sticky on the same edge as a setting op: set wins, sticky_v = 1.
- Wrap-around: sums are modulo 2^WIDTH; carry appears only on cout.

Decomposition:
- Shared package: op-select constants (OP_TFR, OP_ADD, OP_SUB, OP_DEC, logic sub-ops LG_AND/LG_OR/LG_XOR/LG_NOT) and a result-flags struct {c, v, z, n}.
- One natural sub-module: alu_core_comb, a purely combinational WIDTH-parametrised datapath (a, b, s, c_eff -> g, cout, v), instantiated in stage 2.

Test Plan:
- WIDTH=8, a=0x7F, b=0x01, s=001, cin=0 -> g=0x80, v=1, n=1, cout=0, sticky_v=1, out_valid exactly 2 cycles after the input transfer.
- WIDTH=8, a=0x05, b=0x05, s=010, cin=1 -> g=0x00, z=1, cout=1, v=0, flag_c=1.
- Chaining: op1 a=0xFF, b=0x01, s=001, cin=0 (g=0x00, cout=1), then op2 back-to-back with a=0x00, b=0x00, s=001, cin_sel=1 -> g=0x01, cout=0.
- Logic, a=0xF0, b=0x3C, s=1x0 with cin=0/1 and s=1x1 with cin=0/1 -> 0x30, 0xFC, 0xCC, 0x0F; cout=0, v=0; flag_c unchanged.
- Backpressure: hold out_ready=0 while streaming 3 ops -> in_ready drops after 2 accepted ops, g stable. Release -> results emerge in order, no loss, no duplication.
- Assert rst_n low asynchronously with both stages full -> out_valid, flag_c, sticky_v go to 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the pipelined ALU.
// Op-select encodings and the registered result-flag bundle.
package alu_pipe_pkg;

   localparam logic [1:0] OP_TFR = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;
   localparam logic [1:0] OP_DEC = 2'b11;

   localparam logic [1:0] LG_AND = 2'b00;
   localparam logic [1:0] LG_OR  = 2'b01;
   localparam logic [1:0] LG_XOR = 2'b10;
   localparam logic [1:0] LG_NOT = 2'b11;

   typedef struct packed {
      logic c;
      logic v;
      logic z;
      logic n;
   } flags_t;

endpackage

// File: rtl/alu_core_comb.sv
// Combinational ALU datapath: 3-bit select plus carry-in.
// Logic ops are picked by {s[0], c}; s[1] is ignored for them.
module alu_core_comb
   import alu_pipe_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       s,
   input  logic             c_eff,
   output logic [WIDTH-1:0] g,
   output logic             cout,
   output logic             v
);

   logic [WIDTH-1:0] bx;
   logic [WIDTH-1:0] lg;
   logic [WIDTH:0]   sum;
   logic             c_msb;

   always_comb begin
      bx = '0;
      unique case (s[1:0])
         OP_TFR: bx = '0;
         OP_ADD: bx = b;
         OP_SUB: bx = ~b;
         OP_DEC: bx = '1;
      endcase
   end

   assign sum = {1'b0, a} + {1'b0, bx}
              + {{WIDTH{1'b0}}, c_eff};

   // Carry into the MSB recovered from the MSB sum bit.
   assign c_msb = a[WIDTH-1] ^ bx[WIDTH-1] ^ sum[WIDTH-1];

   always_comb begin
      lg = '0;
      unique case ({s[0], c_eff})
         LG_AND: lg = a & b;
         LG_OR:  lg = a | b;
         LG_XOR: lg = a ^ b;
         LG_NOT: lg = ~a;
      endcase
   end

   always_comb begin
      g    = sum[WIDTH-1:0];
      cout = sum[WIDTH];
      v    = c_msb ^ sum[WIDTH];
      if (s[2]) begin
         g    = lg;
         cout = 1'b0;
         v    = 1'b0;
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU with valid/ready flow control, Z/N flags,
// a chained carry flag and a sticky overflow flag.
module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter bit CHAIN_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       s,
   input  logic             cin,
   input  logic             cin_sel,
   input  logic             clr_sticky,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] g,
   output logic             cout,
   output logic             v,
   output logic             z,
   output logic             n,
   output logic             flag_c,
   output logic             sticky_v
);

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [2:0]       s1_s;
   logic             s1_cin;
   logic             s1_cin_sel;

   logic             stage1_ready;
   logic             stage2_ready;
   logic             load;
   logic             c_eff;

   logic [WIDTH-1:0] core_g;
   logic             core_cout;
   logic             core_v;
   flags_t           fl;

   assign stage2_ready = ~out_valid | out_ready;
   assign stage1_ready = ~s1_valid | stage2_ready;
   assign in_ready     = stage1_ready;
   assign load         = s1_valid & stage2_ready;

   // Carry resolved as the op enters the output register,
   // so chained ops see the immediately preceding arith op.
   assign c_eff = (CHAIN_EN && s1_cin_sel && !s1_s[2])
                ? flag_c : s1_cin;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid   <= 1'b0;
         s1_a       <= '0;
         s1_b       <= '0;
         s1_s       <= '0;
         s1_cin     <= 1'b0;
         s1_cin_sel <= 1'b0;
      end else if (stage1_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_a       <= a;
            s1_b       <= b;
            s1_s       <= s;
            s1_cin     <= cin;
            s1_cin_sel <= cin_sel;
         end
      end
   end

   alu_core_comb #(
      .WIDTH (WIDTH)
   ) u_core (
      .a     (s1_a),
      .b     (s1_b),
      .s     (s1_s),
      .c_eff (c_eff),
      .g     (core_g),
      .cout  (core_cout),
      .v     (core_v)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         g         <= '0;
         fl        <= '0;
      end else if (stage2_ready) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            g    <= core_g;
            fl.c <= core_cout;
            fl.v <= core_v;
            fl.z <= ~|core_g;
            fl.n <= core_g[WIDTH-1];
         end
      end
   end

   assign cout = fl.c;
   assign v    = fl.v;
   assign z    = fl.z;
   assign n    = fl.n;

   // A setting op overrides a same-edge clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_c   <= 1'b0;
         sticky_v <= 1'b0;
      end else begin
         if (clr_sticky)
            sticky_v <= 1'b0;
         if (load && !s1_s[2]) begin
            flag_c <= core_cout;
            if (core_v)
               sticky_v <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe at WIDTH=8 with chaining.
// Directed scenarios plus randomized traffic against a reference model.
module tb_alu_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready;
   logic [7:0] a, b;
   logic [2:0] s;
   logic       cin, cin_sel, clr_sticky;
   logic       out_valid, out_ready;
   logic [7:0] g;
   logic       cout, v, z, n, flag_c, sticky_v;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [7:0] g;
      logic       cout;
      logic       v;
      logic       z;
      logic       n;
      logic       fc;
      logic       sv;
   } exp_t;

   exp_t q[$];
   logic m_fc = 1'b0;
   logic m_sv = 1'b0;

   alu_pipe #(
      .WIDTH    (8),
      .CHAIN_EN (1'b1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .s          (s),
      .cin        (cin),
      .cin_sel    (cin_sel),
      .clr_sticky (clr_sticky),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .g          (g),
      .cout       (cout),
      .v          (v),
      .z          (z),
      .n          (n),
      .flag_c     (flag_c),
      .sticky_v   (sticky_v)
   );

   always #5 clk = ~clk;

   // Reference: ops in issue order, signed overflow from integer range.
   task automatic model_push(input logic [7:0] ta, input logic [7:0] tb,
                             input logic [2:0] ts, input logic tc,
                             input logic tcs);
      int   ia, ib, ic, sum, sa, sb, ss;
      exp_t e;
      ia = int'(ta);
      ib = int'(tb);
      e  = '0;
      if (!ts[2]) begin
         ic = (tcs ? int'(m_fc) : int'(tc));
         case (ts[1:0])
            2'd0: ib = 0;
            2'd1: ib = int'(tb);
            2'd2: ib = 255 - int'(tb);
            default: ib = 255;
         endcase
         sum    = ia + ib + ic;
         e.g    = sum[7:0];
         e.cout = (sum > 255);
         sa     = (ia > 127) ? ia - 256 : ia;
         sb     = (ib > 127) ? ib - 256 : ib;
         ss     = sa + sb + ic;
         e.v    = (ss > 127) || (ss < -128);
         m_fc   = e.cout;
         if (e.v) m_sv = 1'b1;
      end else begin
         case ({ts[0], tc})
            2'b00: e.g = ta & tb;
            2'b01: e.g = ta | tb;
            2'b10: e.g = ta ^ tb;
            default: e.g = ~ta;
         endcase
      end
      e.z  = (e.g == 8'd0);
      e.n  = e.g[7];
      e.fc = m_fc;
      e.sv = m_sv;
      q.push_back(e);
   endtask

   task automatic drive(input logic [7:0] ta, input logic [7:0] tb,
                        input logic [2:0] ts, input logic tc,
                        input logic tcs);
      in_valid = 1'b1;
      a = ta; b = tb; s = ts; cin = tc; cin_sel = tcs;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({out_valid, in_ready, flag_c, sticky_v} !== 4'b0100) begin
         errors++;
         $display("FAIL reset_ctl got ov/ir/fc/sv=%b%b%b%b want 0100",
                  out_valid, in_ready, flag_c, sticky_v);
      end
      checks++;
      if ({g, cout, v, z, n} !== 12'h000) begin
         errors++;
         $display("FAIL reset_res got g=%h c=%b v=%b z=%b n=%b want all 0",
                  g, cout, v, z, n);
      end
      @(negedge clk);
      #1 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_add_overflow();
      drive(8'h7F, 8'h01, 3'b001, 1'b0, 1'b0);
      tick();
      idle();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL add_lat1 out_valid got %b want 0", out_valid);
      end
      tick();
      checks++;
      if ({out_valid, g, v, n, cout, z, sticky_v} !== {1'b1, 8'h80, 5'b11001}) begin
         errors++;
         $display("FAIL add_ovf got ov=%b g=%h v=%b n=%b c=%b z=%b sv=%b want 1 80 1 1 0 0 1",
                  out_valid, g, v, n, cout, z, sticky_v);
      end
      tick();
   endtask

   task automatic test_sub_zero();
      drive(8'h05, 8'h05, 3'b010, 1'b1, 1'b0);
      tick();
      idle();
      tick();
      checks++;
      if ({out_valid, g, z, cout, v, n, flag_c} !== {1'b1, 8'h00, 5'b11001}) begin
         errors++;
         $display("FAIL sub_zero got ov=%b g=%h z=%b c=%b v=%b n=%b fc=%b want 1 00 1 1 0 0 1",
                  out_valid, g, z, cout, v, n, flag_c);
      end
      tick();
   endtask

   task automatic test_chain();
      drive(8'hFF, 8'h01, 3'b001, 1'b0, 1'b0);
      tick();
      drive(8'h00, 8'h00, 3'b001, 1'b0, 1'b1);
      tick();
      idle();
      checks++;
      if ({out_valid, g, cout, flag_c} !== {1'b1, 8'h00, 2'b11}) begin
         errors++;
         $display("FAIL chain_op1 got ov=%b g=%h c=%b fc=%b want 1 00 1 1",
                  out_valid, g, cout, flag_c);
      end
      tick();
      checks++;
      if ({out_valid, g, cout, flag_c} !== {1'b1, 8'h01, 2'b00}) begin
         errors++;
         $display("FAIL chain_op2 got ov=%b g=%h c=%b fc=%b want 1 01 0 0",
                  out_valid, g, cout, flag_c);
      end
      tick();
   endtask

   task automatic test_logic();
      logic [7:0] la [5] = '{8'hFF, 8'hF0, 8'hF0, 8'hF0, 8'hF0};
      logic [7:0] lb [5] = '{8'h01, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
      logic [2:0] ls [5] = '{3'b001, 3'b100, 3'b110, 3'b101, 3'b111};
      logic       lc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [7:0] eg [5] = '{8'h00, 8'h30, 8'hFC, 8'hCC, 8'h0F};
      logic       ec [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i <= 5; i++) begin
         if (i < 5) drive(la[i], lb[i], ls[i], lc[i], i != 0);
         else idle();
         tick();
         if (i >= 1) begin
            checks++;
            if ({out_valid, g, cout, v, flag_c} !==
                {1'b1, eg[i-1], ec[i-1], 1'b0, 1'b1}) begin
               errors++;
               $display("FAIL logic_%0d got ov=%b g=%h c=%b v=%b fc=%b want 1 %h %b 0 1",
                        i-1, out_valid, g, cout, v, flag_c, eg[i-1], ec[i-1]);
            end
         end
      end
      tick();
   endtask

   task automatic test_sticky();
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      checks++;
      if (sticky_v !== 1'b0) begin
         errors++;
         $display("FAIL sticky_clr got %b want 0", sticky_v);
      end
      drive(8'h7F, 8'h01, 3'b001, 1'b0, 1'b0);
      tick();
      idle();
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      checks++;
      if ({sticky_v, v} !== 2'b11) begin
         errors++;
         $display("FAIL sticky_setwins got sv=%b v=%b want 1 1", sticky_v, v);
      end
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      checks++;
      if (sticky_v !== 1'b0) begin
         errors++;
         $display("FAIL sticky_clr2 got %b want 0", sticky_v);
      end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      drive(8'h80, 8'h80, 3'b001, 1'b0, 1'b0);
      tick();
      drive(8'h7F, 8'h01, 3'b001, 1'b0, 1'b0);
      tick();
      idle();
      checks++;
      if ({out_valid, in_ready, flag_c, sticky_v} !== 4'b1011) begin
         errors++;
         $display("FAIL areset_pre got ov/ir/fc/sv=%b%b%b%b want 1011",
                  out_valid, in_ready, flag_c, sticky_v);
      end
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, in_ready, flag_c, sticky_v, g} !== {4'b0100, 8'h00}) begin
         errors++;
         $display("FAIL areset_now got ov/ir/fc/sv=%b%b%b%b g=%h want 0100 00",
                  out_valid, in_ready, flag_c, sticky_v, g);
      end
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL areset_flush out_valid got %b want 0", out_valid);
      end
      m_fc = 1'b0;
      m_sv = 1'b0;
      q.delete();
   endtask

   task automatic test_backpressure();
      logic [7:0] pa [3] = '{8'h10, 8'h80, 8'h33};
      logic [7:0] pb [3] = '{8'h20, 8'h80, 8'h0F};
      logic [2:0] ps [3] = '{3'b001, 3'b001, 3'b101};
      int         idx = 0;
      int         got = 0;
      logic       held = 1'b0;
      logic [7:0] hold_g = '0;
      exp_t       e;
      out_ready = 1'b0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (cyc == 6) out_ready = 1'b1;
         if (idx < 3) drive(pa[idx], pb[idx], ps[idx], 1'b0, 1'b0);
         else idle();
         @(negedge clk);
         if (cyc == 5) begin
            checks++;
            if ({in_ready, idx[1:0]} !== 3'b010) begin
               errors++;
               $display("FAIL bp_stall got in_ready=%b accepted=%0d want 0 2",
                        in_ready, idx);
            end
         end
         if (out_valid && !out_ready) begin
            if (held) begin
               checks++;
               if (g !== hold_g) begin
                  errors++;
                  $display("FAIL bp_hold g got %h want %h", g, hold_g);
               end
            end
            hold_g = g;
            held   = 1'b1;
         end
         if (out_valid && out_ready) begin
            checks++;
            e = q.size() > 0 ? q.pop_front() : '0;
            got++;
            if ({g, cout, v, z, n, flag_c, sticky_v} !== e) begin
               errors++;
               $display("FAIL bp_out%0d got %h/%b%b%b%b%b%b want %h/%b%b%b%b%b%b",
                        got, g, cout, v, z, n, flag_c, sticky_v,
                        e.g, e.cout, e.v, e.z, e.n, e.fc, e.sv);
            end
         end
         if (in_valid && in_ready) begin
            model_push(a, b, s, cin, cin_sel);
            idx++;
         end
         tick();
      end
      checks++;
      if (got != 3 || q.size() != 0) begin
         errors++;
         $display("FAIL bp_count got %0d outputs (%0d left) want 3 (0)",
                  got, q.size());
      end
   endtask

   task automatic test_random();
      exp_t e;
      int   nout = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (cyc < 580) begin
            in_valid = ($urandom_range(3) != 0);
            a        = 8'($urandom);
            b        = 8'($urandom);
            s        = 3'($urandom);
            cin      = 1'($urandom);
            cin_sel  = 1'($urandom);
            out_ready = ($urandom_range(3) != 0);
         end else begin
            idle();
            out_ready = 1'b1;
         end
         @(negedge clk);
         if (out_valid && out_ready) begin
            checks++;
            nout++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL rand_extra output %0d with empty model", nout);
            end else begin
               e = q.pop_front();
               if ({g, cout, v, z, n, flag_c, sticky_v} !== e) begin
                  errors++;
                  $display("FAIL rand_out%0d got %h/%b%b%b%b%b%b want %h/%b%b%b%b%b%b",
                           nout, g, cout, v, z, n, flag_c, sticky_v,
                           e.g, e.cout, e.v, e.z, e.n, e.fc, e.sv);
               end
            end
         end
         if (in_valid && in_ready)
            model_push(a, b, s, cin, cin_sel);
         tick();
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL rand_drain %0d results lost", q.size());
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      a          = '0;
      b          = '0;
      s          = '0;
      cin        = 1'b0;
      cin_sel    = 1'b0;
      clr_sticky = 1'b0;
      out_ready  = 1'b1;
      test_reset();
      test_add_overflow();
      test_sub_zero();
      test_chain();
      test_logic();
      test_sticky();
      test_async_reset();
      test_backpressure();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
